// File: rtl/frog_mover_if.sv
// D-pad, game state and frog outputs between frog_mover and its neighbours.
// The master side drives the buttons and game state; frog_mover takes the slave side.
interface frog_mover_if #(
  parameter int X_W = 4,
  parameter int Y_W = 4
);
  logic [3:0]     dpad_input;
  logic [1:0]     state;
  logic [X_W-1:0] frog_x;
  logic [Y_W-1:0] frog_y;
  logic           hop;
  logic           reached_end;

  modport master (
    output dpad_input, state,
    input  frog_x, frog_y, hop, reached_end
  );

  modport slave (
    input  dpad_input, state,
    output frog_x, frog_y, hop, reached_end
  );
endinterface

// File: rtl/frog_mover.sv
// Frog movement: d-pad sync + debounce, one hop per press with cooldown,
// grid bounds, respawn on entry to PLAYING and the registered reached_end level.
module frog_mover #(
  parameter int GRID_COLS       = 16,
  parameter int GRID_ROWS       = 12,
  parameter int START_X         = 7,
  parameter int START_Y         = 11,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int HOP_COOLDOWN    = 1200000
) (
  input logic       clk,
  input logic       reset,
  frog_mover_if.slave bus
);

  localparam int X_W  = $clog2(GRID_COLS);
  localparam int Y_W  = $clog2(GRID_ROWS);
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int CD_W = (HOP_COOLDOWN > 1) ? $clog2(HOP_COOLDOWN) : 1;

  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CD_W-1:0] CD_INIT = CD_W'(HOP_COOLDOWN - 1);
  localparam logic [X_W-1:0]  X_MAX   = X_W'(GRID_COLS - 1);
  localparam logic [Y_W-1:0]  Y_MAX   = Y_W'(GRID_ROWS - 1);
  localparam logic [X_W-1:0]  X_START = X_W'(START_X);
  localparam logic [Y_W-1:0]  Y_START = Y_W'(START_Y);

  typedef enum logic [1:0] {
    ST_MENU    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_DEAD    = 2'd2,
    ST_WIN     = 2'd3
  } game_t;

  typedef enum logic [1:0] {
    ARMED,
    COOLDOWN,
    RELEASE
  } fsm_t;

  // ---------------------------------------------------------------- input conditioning
  logic [3:0]      sync1, sync2, cand, clean;
  logic [DB_W-1:0] db_cnt;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      cand   <= '0;
      clean  <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= bus.dpad_input;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand   <= sync2;
        db_cnt <= '0;
      end else if (db_cnt != DB_MAX) begin
        db_cnt <= db_cnt + 1'b1;
      end else begin
        clean <= cand;
      end
    end
  end

  // ---------------------------------------------------------------- movement FSM
  fsm_t            fsm_q, fsm_d;
  logic [CD_W-1:0] cd_q, cd_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic            hop_q, hop_d;
  logic            end_q;
  game_t           prev_q;
  logic            playing, respawn;

  assign playing = (bus.state == ST_PLAYING);
  // Entering PLAYING re-spawns the frog and swallows the press that left the menu.
  assign respawn = playing && (prev_q != ST_PLAYING);

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q  <= ARMED;
      cd_q   <= '0;
      x_q    <= X_START;
      y_q    <= Y_START;
      hop_q  <= 1'b0;
      end_q  <= 1'b0;
      prev_q <= ST_MENU;
    end else begin
      fsm_q  <= fsm_d;
      cd_q   <= cd_d;
      x_q    <= x_d;
      y_q    <= y_d;
      hop_q  <= hop_d;
      end_q  <= (y_q == '0) && playing && !respawn;
      prev_q <= game_t'(bus.state);
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    fsm_d = fsm_q;
    cd_d  = cd_q;
    x_d   = x_q;
    y_d   = y_q;
    hop_d = 1'b0;

    if (respawn) begin
      x_d   = X_START;
      y_d   = Y_START;
      fsm_d = RELEASE;
    end else begin
      unique case (fsm_q)
        ARMED: begin
          if (clean != 4'd0) begin
            if (playing) begin
              // Fixed priority up > down > left > right; a blocked move still costs a cooldown.
              if (clean[0]) begin
                if (y_q != '0) begin
                  y_d   = y_q - 1'b1;
                  hop_d = 1'b1;
                end
              end else if (clean[1]) begin
                if (y_q != Y_MAX) begin
                  y_d   = y_q + 1'b1;
                  hop_d = 1'b1;
                end
              end else if (clean[2]) begin
                if (x_q != '0) begin
                  x_d   = x_q - 1'b1;
                  hop_d = 1'b1;
                end
              end else begin
                if (x_q != X_MAX) begin
                  x_d   = x_q + 1'b1;
                  hop_d = 1'b1;
                end
              end
              fsm_d = COOLDOWN;
              cd_d  = CD_INIT;
            end else begin
              fsm_d = RELEASE;
            end
          end
        end
        COOLDOWN: begin
          if (cd_q == '0) fsm_d = RELEASE;
          else            cd_d  = cd_q - 1'b1;
        end
        RELEASE: begin
          if (clean == 4'd0) fsm_d = ARMED;
        end
        default: fsm_d = ARMED;
      endcase
    end
  end

  assign bus.frog_x      = x_q;
  assign bus.frog_y      = y_q;
  assign bus.hop         = hop_q;
  assign bus.reached_end = end_q;

endmodule
